// File: rtl/kgp_isa_pkg.sv
// kgp_isa_pkg: KGP mini-RISC instruction fields, opcode/func constants and loader states
package kgp_isa_pkg;
   localparam int INSTR_W  = 32;
   localparam int OPC_W    = 6;
   localparam int FUNC_W   = 6;
   localparam int OPC_LSB  = 26;
   localparam int FUNC_LSB = 0;
   localparam logic [OPC_W-1:0] OP_ARITH  = 6'd0;
   localparam logic [OPC_W-1:0] OP_ARITHI = 6'd1;
   localparam logic [OPC_W-1:0] OP_LOGIC  = 6'd10;
   localparam logic [OPC_W-1:0] OP_SHIFT  = 6'd20;
   localparam logic [OPC_W-1:0] OP_SHIFTV = 6'd21;
   localparam logic [OPC_W-1:0] OP_LW     = 6'd30;
   localparam logic [OPC_W-1:0] OP_SW     = 6'd31;
   localparam logic [OPC_W-1:0] OP_B      = 6'd40;
   localparam logic [OPC_W-1:0] OP_BNZ    = 6'd47;
   localparam logic [OPC_W-1:0] OP_DIFF   = 6'd50;
   localparam logic [FUNC_W-1:0] F_ADD = 6'd0;
   localparam logic [FUNC_W-1:0] F_SUB = 6'd1;
   localparam logic [FUNC_W-1:0] F_SLL = 6'd0;
   localparam logic [FUNC_W-1:0] F_SRL = 6'd1;
   localparam logic [FUNC_W-1:0] F_SRA = 6'd2;
   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_BYTES, S_WRITE, S_DONE, S_ERR
   } ld_state_t;
endpackage

// File: rtl/instr_legal_check.sv
// instr_legal_check: combinational test of an opcode/func pair against the decoder's implemented set
module instr_legal_check
   import kgp_isa_pkg::*;
(
   input  logic [OPC_W-1:0]  opcode,
   input  logic [FUNC_W-1:0] func,
   output logic              legal
);
   assign legal = ((opcode == OP_ARITH || opcode == OP_ARITHI || opcode == OP_LOGIC) && func <= F_SUB)
                || ((opcode == OP_SHIFT || opcode == OP_SHIFTV) && func <= F_SRA)
                || opcode == OP_LW || opcode == OP_SW
                || (opcode >= OP_B && opcode <= OP_BNZ)
                || opcode == OP_DIFF;
endmodule

// File: rtl/program_loader.sv
// program_loader: streams a length-prefixed big-endian image into imem; LOADER_LEGAL_CHECK_EN rejects undecodable words
module program_loader
   import kgp_isa_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [7:0]         in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic [INSTR_W-1:0] imem_wdata,
   output logic               imem_we,
   output logic               cpu_hold,
   output logic               done,
   output logic               err,
   output logic [ADDR_W-1:0]  err_addr
);
   ld_state_t          state, nxt_state;
   logic [15:0]        len, nxt_len, n_word;
   logic [ADDR_W:0]    cnt, nxt_cnt, cnt_inc;
   logic [1:0]         bcnt, nxt_bcnt;
   logic [23:0]        sh, nxt_sh;
   logic [INSTR_W-1:0] word, nxt_wdata;
   logic [ADDR_W-1:0]  nxt_err_addr;
   logic               nxt_done, nxt_err, nxt_hold, xfer, legal, oversize, last;
   assign xfer      = in_valid & in_ready;
   assign word      = {sh, in_data};
   assign n_word    = {len[7:0], in_data};
   assign cnt_inc   = cnt + 1'b1;
   assign oversize  = 32'(n_word) > (32'd1 << ADDR_W);
   assign last      = 32'(cnt_inc) == 32'(len);
   assign imem_addr = cnt[ADDR_W-1:0];
`ifdef LOADER_LEGAL_CHECK_EN
   instr_legal_check u_legal (
      .opcode (word[OPC_LSB +: OPC_W]),
      .func   (word[FUNC_LSB +: FUNC_W]),
      .legal  (legal)
   );
`else
   assign legal = 1'b1;
`endif
   // next state and next register values; the word is screened on its 4th byte so a rejected word never strobes imem_we
   always_comb begin
      nxt_state    = state;
      nxt_len      = len;
      nxt_cnt      = cnt;
      nxt_bcnt     = bcnt;
      nxt_sh       = sh;
      nxt_wdata    = imem_wdata;
      nxt_done     = done;
      nxt_err      = err;
      nxt_err_addr = err_addr;
      nxt_hold     = cpu_hold;
      case (state)
         S_IDLE, S_DONE, S_ERR: if (start) begin
            nxt_state    = S_LEN_HI;
            nxt_hold     = 1'b1;
            nxt_done     = 1'b0;
            nxt_err      = 1'b0;
            nxt_err_addr = '0;
            nxt_cnt      = '0;
            nxt_bcnt     = '0;
         end
         S_LEN_HI: if (xfer) begin
            nxt_len   = {8'h00, in_data};
            nxt_state = S_LEN_LO;
         end
         S_LEN_LO: if (xfer) begin
            nxt_len   = n_word;
            nxt_state = n_word == 16'd0 ? S_DONE : oversize ? S_ERR : S_BYTES;
            nxt_done  = n_word == 16'd0;
            nxt_hold  = n_word != 16'd0;
            nxt_err   = n_word != 16'd0 && oversize;
         end
         S_BYTES: if (xfer) begin
            nxt_sh   = word[23:0];
            nxt_bcnt = bcnt + 2'd1;
            if (bcnt == 2'd3) begin
               nxt_state    = legal ? S_WRITE : S_ERR;
               nxt_err      = !legal;
               nxt_err_addr = legal ? err_addr : cnt[ADDR_W-1:0];
               nxt_wdata    = legal ? word : imem_wdata;
            end
         end
         S_WRITE: begin
            nxt_cnt   = cnt_inc;
            nxt_state = last ? S_DONE : S_BYTES;
            nxt_done  = last;
            nxt_hold  = !last;
         end
         default: nxt_state = S_IDLE;
      endcase
   end
   // state and registered outputs; handshake and strobe are decoded from the next state so they are flop outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         len        <= '0;
         cnt        <= '0;
         bcnt       <= '0;
         sh         <= '0;
         imem_wdata <= '0;
         imem_we    <= 1'b0;
         in_ready   <= 1'b0;
         cpu_hold   <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         err_addr   <= '0;
      end else begin
         state      <= nxt_state;
         len        <= nxt_len;
         cnt        <= nxt_cnt;
         bcnt       <= nxt_bcnt;
         sh         <= nxt_sh;
         imem_wdata <= nxt_wdata;
         imem_we    <= nxt_state == S_WRITE;
         in_ready   <= nxt_state inside {S_LEN_HI, S_LEN_LO, S_BYTES};
         cpu_hold   <= nxt_hold;
         done       <= nxt_done;
         err        <= nxt_err;
         err_addr   <= nxt_err_addr;
      end
   end
endmodule
